// File: rtl/safe_lock_ctrl_if.sv
// ----------------------------------------------------------------------------
// safe_lock_ctrl_if
// Keypad / status bundle between the keypad header and safe_lock_ctrl.
//   key_code     : raw 4-bit keypad code (asynchronous to the controller clock)
//   key_validn   : raw keypad strobe, active-low (asynchronous)
//   is_open      : safe is open (OPEN or ENTER_PW)
//   in_lockout   : timed lockout in progress
//   key_pulse    : one-cycle strobe per accepted key press
//   key_val      : code captured with the most recent key_pulse
//   entry_len    : digits currently held in the entry buffer
//   entry_digits : entry buffer, digit i at [4i+3:4i], digit 0 typed first
//   fail_count   : consecutive failed unlock attempts
// The master modport is the keypad/display side, the slave modport is the
// controller.
// ----------------------------------------------------------------------------
interface safe_lock_ctrl_if #(
   parameter int CODE_LEN = 6
);
   logic [3:0]            key_code;
   logic                  key_validn;
   logic                  is_open;
   logic                  in_lockout;
   logic                  key_pulse;
   logic [3:0]            key_val;
   logic [3:0]            entry_len;
   logic [4*CODE_LEN-1:0] entry_digits;
   logic [3:0]            fail_count;

   modport master (
      output key_code, key_validn,
      input  is_open, in_lockout, key_pulse, key_val,
             entry_len, entry_digits, fail_count
   );

   modport slave (
      input  key_code, key_validn,
      output is_open, in_lockout, key_pulse, key_val,
             entry_len, entry_digits, fail_count
   );
endinterface

// File: rtl/safe_lock_ctrl.sv
// ----------------------------------------------------------------------------
// safe_lock_ctrl
// Keypad safe controller: synchronises the raw keypad bus, converts each
// press into a single key event and runs the set-code / lock / unlock state
// machine with a timed lockout after MAX_FAILS consecutive wrong codes.
// Ports:
//   MAX10_CLK1_50 : clock, all logic on the rising edge
//   reset         : synchronous, active-low
//   bus           : safe_lock_ctrl_if.slave (keypad inputs, status outputs)
// Parameters:
//   CODE_LEN    : digits per code (1..8)
//   MAX_FAILS   : wrong codes that trigger lockout (1..15)
//   LOCKOUT_CYC : lockout duration in clock cycles
// ----------------------------------------------------------------------------
module safe_lock_ctrl #(
   parameter int CODE_LEN    = 6,
   parameter int MAX_FAILS   = 3,
   parameter int LOCKOUT_CYC = 500_000_000
) (
   input  logic              MAX10_CLK1_50,
   input  logic              reset,
   safe_lock_ctrl_if.slave   bus
);

   localparam logic [2:0] ST_OPEN      = 3'd0;
   localparam logic [2:0] ST_ENTER_PW  = 3'd1;
   localparam logic [2:0] ST_LOCKED    = 3'd2;
   localparam logic [2:0] ST_ENTER_TRY = 3'd3;
   localparam logic [2:0] ST_CHECK     = 3'd4;
   localparam logic [2:0] ST_PENALTY   = 3'd5;

   localparam int             CNT_W    = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOCKOUT_CYC - 1);
   localparam logic [3:0]     FULL_LEN = 4'(CODE_LEN);
   localparam logic [3:0]     FAIL_LIM = 4'(MAX_FAILS);

   typedef logic [CODE_LEN-1:0][3:0] digits_t;

   // synchroniser and key event detector
   logic [3:0]       code_s1_q, code_s1_d;
   logic [3:0]       code_s2_q, code_s2_d;
   logic             vld_s1_q, vld_s1_d;
   logic             vld_s2_q, vld_s2_d;
   logic [1:0]       low_cnt_q, low_cnt_d;
   logic             key_pulse_q, key_pulse_d;
   logic [3:0]       key_val_q, key_val_d;

   // state machine and buffers
   logic [2:0]       state_q, state_d;
   digits_t          entry_q, entry_d;
   logic [3:0]       entry_len_q, entry_len_d;
   digits_t          code_q, code_d;
   logic [3:0]       fail_q, fail_d;
   logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;

   logic             is_digit;
   logic             is_clear;
   logic [3:0]       fail_inc;

   always_comb begin
      code_s1_d = bus.key_code;
      code_s2_d = code_s1_q;
      vld_s1_d  = bus.key_validn;
      vld_s2_d  = vld_s1_q;

      // Low-time counter saturates at 3 so a held key produces one event only.
      // The event fires on the 2->3 step, i.e. after three synchronised lows.
      if (vld_s2_q) begin
         low_cnt_d = 2'd0;
      end else if (low_cnt_q != 2'd3) begin
         low_cnt_d = low_cnt_q + 2'd1;
      end else begin
         low_cnt_d = low_cnt_q;
      end
      key_pulse_d = !vld_s2_q && (low_cnt_q == 2'd2);
      key_val_d   = key_pulse_d ? code_s2_q : key_val_q;

      state_d     = state_q;
      entry_d     = entry_q;
      entry_len_d = entry_len_q;
      code_d      = code_q;
      fail_d      = fail_q;
      lock_cnt_d  = lock_cnt_q;

      // The FSM acts on the registered event, one edge after key_pulse rises.
      is_digit = (key_val_q <= 4'hD);
      is_clear = (key_val_q == 4'hF);
      fail_inc = fail_q + 4'd1;

      case (state_q)
         ST_OPEN, ST_LOCKED: begin
            if (key_pulse_q && is_digit) begin
               state_d     = (state_q == ST_OPEN) ? ST_ENTER_PW : ST_ENTER_TRY;
               entry_d     = '0;
               entry_d[0]  = key_val_q;
               entry_len_d = 4'd1;
            end
         end

         ST_ENTER_PW, ST_ENTER_TRY: begin
            if (key_pulse_q) begin
               if (is_digit) begin
                  if (entry_len_q < FULL_LEN) begin
                     for (int i = 0; i < CODE_LEN; i++) begin
                        if (4'(i) == entry_len_q) entry_d[i] = key_val_q;
                     end
                     entry_len_d = entry_len_q + 4'd1;
                  end
               end else if (is_clear) begin
                  entry_d     = '0;
                  entry_len_d = 4'd0;
                  state_d     = (state_q == ST_ENTER_PW) ? ST_OPEN : ST_LOCKED;
               end else if (entry_len_q == FULL_LEN) begin
                  // Enter with a full buffer; short entries are ignored silently.
                  if (state_q == ST_ENTER_PW) begin
                     code_d      = entry_q;
                     entry_d     = '0;
                     entry_len_d = 4'd0;
                     state_d     = ST_LOCKED;
                  end else begin
                     state_d = ST_CHECK;
                  end
               end
            end
         end

         ST_CHECK: begin
            entry_d     = '0;
            entry_len_d = 4'd0;
            if (entry_q == code_q) begin
               state_d = ST_OPEN;
               fail_d  = 4'd0;
            end else begin
               fail_d = fail_inc;
               if (fail_inc == FAIL_LIM) begin
                  state_d    = ST_PENALTY;
                  lock_cnt_d = CNT_LOAD;
               end else begin
                  state_d = ST_LOCKED;
               end
            end
         end

         ST_PENALTY: begin
            // Loaded with LOCKOUT_CYC-1 so PENALTY lasts exactly LOCKOUT_CYC cycles.
            if (lock_cnt_q == '0) begin
               state_d = ST_LOCKED;
               fail_d  = 4'd0;
            end else begin
               lock_cnt_d = lock_cnt_q - 1'b1;
            end
         end

         default: state_d = ST_OPEN;
      endcase
   end

   always_ff @(posedge MAX10_CLK1_50) begin
      if (!reset) begin
         code_s1_q   <= 4'h0;
         code_s2_q   <= 4'h0;
         vld_s1_q    <= 1'b1;
         vld_s2_q    <= 1'b1;
         low_cnt_q   <= 2'd0;
         key_pulse_q <= 1'b0;
         key_val_q   <= 4'h0;
         state_q     <= ST_OPEN;
         entry_q     <= '0;
         entry_len_q <= 4'd0;
         code_q      <= '0;
         fail_q      <= 4'd0;
         lock_cnt_q  <= '0;
      end else begin
         code_s1_q   <= code_s1_d;
         code_s2_q   <= code_s2_d;
         vld_s1_q    <= vld_s1_d;
         vld_s2_q    <= vld_s2_d;
         low_cnt_q   <= low_cnt_d;
         key_pulse_q <= key_pulse_d;
         key_val_q   <= key_val_d;
         state_q     <= state_d;
         entry_q     <= entry_d;
         entry_len_q <= entry_len_d;
         code_q      <= code_d;
         fail_q      <= fail_d;
         lock_cnt_q  <= lock_cnt_d;
      end
   end

   assign bus.is_open      = (state_q == ST_OPEN) || (state_q == ST_ENTER_PW);
   assign bus.in_lockout   = (state_q == ST_PENALTY);
   assign bus.key_pulse    = key_pulse_q;
   assign bus.key_val      = key_val_q;
   assign bus.entry_len    = entry_len_q;
   assign bus.entry_digits = entry_q;
   assign bus.fail_count   = fail_q;

endmodule

// File: tb/tb_safe_lock_ctrl.sv
// ----------------------------------------------------------------------------
// tb_safe_lock_ctrl
// Directed bench for safe_lock_ctrl with CODE_LEN=6, MAX_FAILS=3,
// LOCKOUT_CYC=20. Each key press pushes its expected key value and the
// expected status two cycles after the key event onto a scoreboard queue; a
// monitor pops an entry on every key_pulse and compares.
// ----------------------------------------------------------------------------
module tb_safe_lock_ctrl;
   localparam int CODE_LEN    = 6;
   localparam int MAX_FAILS   = 3;
   localparam int LOCKOUT_CYC = 20;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   safe_lock_ctrl_if #(.CODE_LEN(CODE_LEN)) bus ();

   safe_lock_ctrl #(
      .CODE_LEN    (CODE_LEN),
      .MAX_FAILS   (MAX_FAILS),
      .LOCKOUT_CYC (LOCKOUT_CYC)
   ) dut (
      .MAX10_CLK1_50 (clk),
      .reset         (reset),
      .bus           (bus)
   );

   typedef struct {
      logic [3:0] key;
      logic       open;
      logic       lock;
      logic [3:0] len;
      logic [3:0] fails;
   } exp_t;

   exp_t sb_q[$];
   exp_t cur;
   int   pend        = 0;
   int   total       = 0;
   int   bad         = 0;
   int   lock_cycles = 0;
   int   pulses      = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: key value at the pulse, status two cycles later.
   always @(negedge clk) begin
      if (reset) begin
         if (bus.in_lockout) lock_cycles++;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               chk("is_open",    32'(bus.is_open),    32'(cur.open));
               chk("in_lockout", 32'(bus.in_lockout), 32'(cur.lock));
               chk("entry_len",  32'(bus.entry_len),  32'(cur.len));
               chk("fail_count", 32'(bus.fail_count), 32'(cur.fails));
            end
         end
         if (bus.key_pulse) begin
            pulses++;
            if (sb_q.size() == 0) begin
               chk("unexpected_key_pulse", 32'd1, 32'd0);
            end else begin
               cur = sb_q.pop_front();
               chk("key_val", 32'(bus.key_val), 32'(cur.key));
               pend = 2;
            end
         end
      end
   end

   task automatic press(input logic [3:0] k, input int low_cyc, input logic o, input logic l,
                        input logic [3:0] len, input logic [3:0] f);
      exp_t e;
      e.key = k; e.open = o; e.lock = l; e.len = len; e.fails = f;
      sb_q.push_back(e);
      @(negedge clk);
      bus.key_code   = k;
      bus.key_validn = 1'b0;
      repeat (low_cyc) @(negedge clk);
      bus.key_validn = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   int p0;

   initial begin
      bus.key_code   = 4'h0;
      bus.key_validn = 1'b1;
      reset          = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_is_open",    32'(bus.is_open),      32'd1);
      chk("rst_in_lockout", 32'(bus.in_lockout),   32'd0);
      chk("rst_key_pulse",  32'(bus.key_pulse),    32'd0);
      chk("rst_key_val",    32'(bus.key_val),      32'd0);
      chk("rst_entry_len",  32'(bus.entry_len),    32'd0);
      chk("rst_digits",     32'(bus.entry_digits), 32'd0);
      chk("rst_fail_count", 32'(bus.fail_count),   32'd0);

      // set code 123456
      for (int i = 1; i <= 6; i++) press(4'(i), 5, 1'b1, 1'b0, 4'(i), 4'd0);
      press(4'hE, 5, 1'b0, 1'b0, 4'd0, 4'd0);
      chk("set_digits_cleared", 32'(bus.entry_digits), 32'd0);

      // short entry + Enter is ignored, Clear returns to LOCKED
      for (int i = 1; i <= 3; i++) press(4'(i), 5, 1'b0, 1'b0, 4'(i), 4'd0);
      press(4'hE, 5, 1'b0, 1'b0, 4'd3, 4'd0);
      chk("short_digits", 32'(bus.entry_digits), 32'h000321);
      press(4'hF, 5, 1'b0, 1'b0, 4'd0, 4'd0);

      // unlock, with a 7th digit ignored
      for (int i = 1; i <= 6; i++) press(4'(i), 5, 1'b0, 1'b0, 4'(i), 4'd0);
      press(4'h7, 5, 1'b0, 1'b0, 4'd6, 4'd0);
      chk("full_digits", 32'(bus.entry_digits), 32'h654321);
      press(4'hE, 5, 1'b1, 1'b0, 4'd0, 4'd0);

      // relock with 123456
      for (int i = 1; i <= 6; i++) press(4'(i), 5, 1'b1, 1'b0, 4'(i), 4'd0);
      press(4'hE, 5, 1'b0, 1'b0, 4'd0, 4'd0);

      // three wrong codes -> lockout
      lock_cycles = 0;
      for (int t = 1; t <= 3; t++) begin
         for (int i = 1; i <= 6; i++) press(4'h9, 5, 1'b0, 1'b0, 4'(i), 4'(t - 1));
         press(4'hE, 5, 1'b0, (t == 3), 4'd0, 4'(t));
      end
      press(4'h5, 5, 1'b0, 1'b1, 4'd0, 4'd3);
      repeat (25) @(negedge clk);
      chk("lockout_cycles",     32'(lock_cycles),    32'(LOCKOUT_CYC));
      chk("post_lock_inlock",   32'(bus.in_lockout), 32'd0);
      chk("post_lock_fails",    32'(bus.fail_count), 32'd0);
      chk("post_lock_is_open",  32'(bus.is_open),    32'd0);
      chk("post_lock_len",      32'(bus.entry_len),  32'd0);

      // 2-cycle glitch: no event
      p0 = pulses;
      @(negedge clk);
      bus.key_code   = 4'h3;
      bus.key_validn = 1'b0;
      repeat (2) @(negedge clk);
      bus.key_validn = 1'b1;
      repeat (10) @(negedge clk);
      chk("glitch_pulses", 32'(pulses), 32'(p0));

      // 100-cycle hold: exactly one event
      p0 = pulses;
      press(4'h4, 100, 1'b0, 1'b0, 4'd1, 4'd0);
      chk("hold_pulses", 32'(pulses), 32'(p0 + 1));

      // reset in the middle of ENTER_TRY
      press(4'h5, 5, 1'b0, 1'b0, 4'd2, 4'd0);
      press(4'h6, 5, 1'b0, 1'b0, 4'd3, 4'd0);
      chk("mid_len", 32'(bus.entry_len), 32'd3);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_is_open", 32'(bus.is_open),      32'd1);
      chk("mid_rst_len",     32'(bus.entry_len),    32'd0);
      chk("mid_rst_digits",  32'(bus.entry_digits), 32'd0);
      chk("mid_rst_fails",   32'(bus.fail_count),   32'd0);
      chk("mid_rst_key_val", 32'(bus.key_val),      32'd0);

      // code 000000 then unlock with it
      for (int i = 1; i <= 6; i++) press(4'h0, 5, 1'b1, 1'b0, 4'(i), 4'd0);
      press(4'hE, 5, 1'b0, 1'b0, 4'd0, 4'd0);
      for (int i = 1; i <= 6; i++) press(4'h0, 5, 1'b0, 1'b0, 4'(i), 4'd0);
      press(4'hE, 5, 1'b1, 1'b0, 4'd0, 4'd0);

      repeat (10) @(negedge clk);
      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
